// File: rtl/vga_sync_pkg.sv
// vga_sync_pkg: shared timing constants and phase enumeration for the VGA
// sync generator. The *_DEF values describe standard 640x480@60 timing and
// serve as parameter defaults; H_TOTAL/V_TOTAL are derived from them.
package vga_sync_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis (horizontal or vertical). A position counter
// advancing on en and wrapping at the axis total, plus a phase FSM
// VISIBLE -> FRONT -> SYNC -> BACK that follows the counter.
// Ports:
//   CLK_NX      in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   en          in   advance the axis by one position this cycle
//   cnt         out  registered position, 0..TOTAL-1
//   wrap        out  combinational: en is high and cnt is at TOTAL-1
//   sync_active out  registered: FSM is in SYNC (aligned with cnt)
//   visible_nxt out  combinational: FSM will be in VISIBLE after this cycle
module vga_axis_cnt
  import vga_sync_pkg::*;
#(
  parameter int N_VISIBLE = H_VISIBLE_DEF,
  parameter int N_FRONT   = H_FRONT_DEF,
  parameter int N_SYNC    = H_SYNC_DEF,
  parameter int N_BACK    = H_BACK_DEF
) (
  input  logic             CLK_NX,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync_active,
  output logic             visible_nxt
);

  localparam int TOTAL = N_VISIBLE + N_FRONT + N_SYNC + N_BACK;

  localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(N_VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(N_VISIBLE + N_FRONT);
  localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(N_VISIBLE + N_FRONT + N_SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;
  logic             sync_active_q;

  // Phase transitions are decided from the next count, so the registered
  // phase and count always describe the same position.
  always_comb begin
    wrap    = en && (cnt_q == LAST);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      unique case (phase_q)
        VISIBLE: if (cnt_d == FRONT_START) phase_d = FRONT;
        FRONT:   if (cnt_d == SYNC_START)  phase_d = SYNC;
        SYNC:    if (cnt_d == BACK_START)  phase_d = BACK;
        BACK:    if (cnt_d == '0)          phase_d = VISIBLE;
      endcase
    end
  end

  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      phase_q       <= VISIBLE;
      sync_active_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      sync_active_q <= (phase_d == SYNC);
    end
  end

  assign cnt         = cnt_q;
  assign sync_active = sync_active_q;
  assign visible_nxt = (phase_d == VISIBLE);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator. Two vga_axis_cnt instances form the
// horizontal and vertical axes; the vertical axis advances on each line wrap.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to add an 8-bit frame counter.
// Ports:
//   CLK_NX      in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   pixel_tick  in   one-cycle pixel enable from the clock divider
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   video_on    out  position is inside the visible area
//   pixel_x     out  horizontal position
//   pixel_y     out  vertical position
//   line_end    out  one-cycle pulse after the tick that wraps pixel_x
//   frame_end   out  one-cycle pulse after the tick that wraps pixel_x and pixel_y
//   frame_cnt   out  frames completed modulo 256 (VGA_SYNC_FRAME_CNT_EN only)
module vga_sync_gen
  import vga_sync_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             CLK_NX,
  input  logic             reset,
  input  logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_end
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  logic h_wrap, h_sync_active, h_visible_nxt;
  logic v_wrap, v_sync_active, v_visible_nxt;

  vga_axis_cnt #(
    .N_VISIBLE (H_VISIBLE),
    .N_FRONT   (H_FRONT),
    .N_SYNC    (H_SYNC),
    .N_BACK    (H_BACK)
  ) u_h_axis (
    .CLK_NX      (CLK_NX),
    .reset       (reset),
    .en          (pixel_tick),
    .cnt         (pixel_x),
    .wrap        (h_wrap),
    .sync_active (h_sync_active),
    .visible_nxt (h_visible_nxt)
  );

  // The vertical axis steps once per line, on the tick that wraps pixel_x.
  vga_axis_cnt #(
    .N_VISIBLE (V_VISIBLE),
    .N_FRONT   (V_FRONT),
    .N_SYNC    (V_SYNC),
    .N_BACK    (V_BACK)
  ) u_v_axis (
    .CLK_NX      (CLK_NX),
    .reset       (reset),
    .en          (h_wrap),
    .cnt         (pixel_y),
    .wrap        (v_wrap),
    .sync_active (v_sync_active),
    .visible_nxt (v_visible_nxt)
  );

  logic video_on_q, video_on_d;
  logic line_end_q, line_end_d;
  logic frame_end_q, frame_end_d;

  // Pulses are set straight from the wrap conditions, so they fall back to 0
  // on the next cycle because a wrap cannot repeat on consecutive cycles
  // unless the axis total is 1.
  always_comb begin
    video_on_d  = h_visible_nxt && v_visible_nxt;
    line_end_d  = h_wrap;
    frame_end_d = h_wrap && v_wrap;
  end

  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      video_on_q  <= 1'b1;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      video_on_q  <= video_on_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign hsync     = ~h_sync_active;
  assign vsync     = ~v_sync_active;
  assign video_on  = video_on_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts up on the same edge that raises frame_end.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {7'd0, frame_end_d};
  end

  always_ff @(posedge CLK_NX or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Instance A uses the default 640x480 timing for
// the horizontal checks; instance B uses a tiny 8x7 raster so whole frames
// (and many frames for the optional frame counter) fit in a short run.
// Instance B timing: H 4/1/2/1 (total 8), V 3/1/2/1 (total 7).
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_a = 1'b0;
  logic       tick_b = 1'b0;
  logic       hs_a, vs_a, von_a, le_a, fe_a;
  logic       hs_b, vs_b, von_b, le_b, fe_b;
  logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] fc_a, fc_b;
`endif

  always #5 clk = ~clk;

  vga_sync_gen u_a (
    .CLK_NX     (clk),
    .reset      (rst_n),
    .pixel_tick (tick_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .video_on   (von_a),
    .pixel_x    (x_a),
    .pixel_y    (y_a),
    .line_end   (le_a),
    .frame_end  (fe_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt  (fc_a)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (3), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_b (
    .CLK_NX     (clk),
    .reset      (rst_n),
    .pixel_tick (tick_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .video_on   (von_b),
    .pixel_x    (x_b),
    .pixel_y    (y_b),
    .line_end   (le_b),
    .frame_end  (fe_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt  (fc_b)
`endif
  );

  // kind 0: output snapshot of one instance; kind 1: pulse counts of B.
  typedef struct {
    int         cyc;
    int         kind;
    bit         dut_b;
    string      tag;
    logic [9:0] x, y;
    logic       hs, vs, von, le, fe;
    logic [7:0] fc;
    int         n_le, n_fe, n_vsl;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_le = 0, n_fe = 0, n_vsl = 0;
  bit   cnt_en = 1'b0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_st(input string tag, input bit b, input int off,
                                 input int x, input int y, input bit hs, input bit vs,
                                 input bit von, input bit le, input bit fe, input int fc);
    exp_t e;
    e.cyc = cyc + off; e.kind = 0; e.dut_b = b; e.tag = tag;
    e.x = 10'(x); e.y = 10'(y); e.hs = hs; e.vs = vs; e.von = von;
    e.le = le; e.fe = fe; e.fc = 8'(fc);
    e.n_le = 0; e.n_fe = 0; e.n_vsl = 0;
    q.push_back(e);
  endfunction

  function automatic void exp_cnt(input string tag, input int nle, input int nfe, input int nvsl);
    exp_t e;
    e.cyc = cyc; e.kind = 1; e.dut_b = 1'b1; e.tag = tag;
    e.x = '0; e.y = '0; e.hs = 1'b0; e.vs = 1'b0; e.von = 1'b0;
    e.le = 1'b0; e.fe = 1'b0; e.fc = '0;
    e.n_le = nle; e.n_fe = nfe; e.n_vsl = nvsl;
    q.push_back(e);
  endfunction

  // Monitor: counts B's pulses inside the window and checks queued entries
  // on the falling edge of the cycle they were scheduled for.
  always @(negedge clk) begin
    exp_t       e;
    logic [9:0] ax, ay;
    logic       ahs, avs, avon, ale, afe;
    logic [7:0] afc;
    bit         bad;
    if (cnt_en) begin
      if (le_b) n_le++;
      if (fe_b) n_fe++;
      if (le_b && !vs_b) n_vsl++;
    end
    while (q.size() > 0 && (q[0].cyc <= cyc || done)) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: scheduled for cycle %0d, reached cycle %0d", e.tag, e.cyc, cyc);
      end else if (e.kind == 1) begin
        if (n_le != e.n_le || n_fe != e.n_fe || n_vsl != e.n_vsl) begin
          miscompares++;
          $display("FAIL %s: got line_end=%0d frame_end=%0d vsync_lines=%0d, want %0d %0d %0d",
                   e.tag, n_le, n_fe, n_vsl, e.n_le, e.n_fe, e.n_vsl);
        end
      end else begin
        afc = '0;
        if (e.dut_b) begin
          ax = x_b; ay = y_b; ahs = hs_b; avs = vs_b; avon = von_b; ale = le_b; afe = fe_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
          afc = fc_b;
`endif
        end else begin
          ax = x_a; ay = y_a; ahs = hs_a; avs = vs_a; avon = von_a; ale = le_a; afe = fe_a;
`ifdef VGA_SYNC_FRAME_CNT_EN
          afc = fc_a;
`endif
        end
        bad = (ax !== e.x) || (ay !== e.y) || (ahs !== e.hs) || (avs !== e.vs) ||
              (avon !== e.von) || (ale !== e.le) || (afe !== e.fe);
`ifdef VGA_SYNC_FRAME_CNT_EN
        bad = bad || (afc !== e.fc);
`endif
        if (bad) begin
          miscompares++;
          $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b le=%b fe=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b von=%b le=%b fe=%b fc=%0d",
                   e.tag, ax, ay, ahs, avs, avon, ale, afe, afc,
                   e.x, e.y, e.hs, e.vs, e.von, e.le, e.fe, e.fc);
        end
      end
    end
  end

  // Pixel ticks every second cycle, as from the divider.
  task automatic ticks_a(input int n);
    repeat (n) begin
      @(posedge clk); #1 tick_a = 1'b1;
      @(posedge clk); #1 tick_a = 1'b0;
    end
  endtask

  task automatic ticks_b(input int n);
    repeat (n) begin
      @(posedge clk); #1 tick_b = 1'b1;
      @(posedge clk); #1 tick_b = 1'b0;
    end
  endtask

  // pixel_tick held high for n consecutive edges.
  task automatic hold_a(input int n);
    @(posedge clk); #1 tick_a = 1'b1;
    repeat (n) @(posedge clk);
    #1 tick_a = 1'b0;
  endtask

  task automatic hold_b(input int n);
    @(posedge clk); #1 tick_b = 1'b1;
    repeat (n) @(posedge clk);
    #1 tick_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    exp_st("reset_a", 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    exp_st("reset_b", 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt_en = 1'b1;

    // First tick after release
    ticks_a(1);
    exp_st("first_tick_a", 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);

    // Horizontal phase boundaries on the default raster
    ticks_a(638); exp_st("x639_a", 0, 0, 639, 0, 1, 1, 1, 0, 0, 0);
    ticks_a(1);   exp_st("x640_a", 0, 0, 640, 0, 1, 1, 0, 0, 0, 0);
    ticks_a(15);  exp_st("x655_a", 0, 0, 655, 0, 1, 1, 0, 0, 0, 0);
    ticks_a(1);   exp_st("x656_a", 0, 0, 656, 0, 0, 1, 0, 0, 0, 0);
    ticks_a(95);  exp_st("x751_a", 0, 0, 751, 0, 0, 1, 0, 0, 0, 0);
    ticks_a(1);   exp_st("x752_a", 0, 0, 752, 0, 1, 1, 0, 0, 0, 0);
    ticks_a(47);  exp_st("x799_a", 0, 0, 799, 0, 1, 1, 0, 0, 0, 0);
    ticks_a(1);
    exp_st("line_wrap_a", 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
    exp_st("line_pulse_end_a", 0, 1, 0, 1, 1, 1, 1, 0, 0, 0);
    exp_st("hold_no_tick_a", 0, 3, 0, 1, 1, 1, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    // Continuous ticks: one step per cycle
    hold_a(10);
    exp_st("continuous_a", 0, 0, 10, 1, 1, 1, 1, 0, 0, 0);

    // Full frame on the small raster
    ticks_b(1);  exp_st("first_tick_b", 1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    ticks_b(31); exp_st("vsync_start_b", 1, 0, 0, 4, 1, 0, 0, 1, 0, 0);
    ticks_b(23); exp_st("frame_last_b", 1, 0, 7, 6, 1, 1, 0, 0, 0, 0);
    ticks_b(1);
    exp_st("frame_wrap_b", 1, 0, 0, 0, 1, 1, 1, 1, 1, 1);
    exp_st("frame_pulse_end_b", 1, 1, 0, 0, 1, 1, 1, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 cnt_en = 1'b0;
    exp_cnt("frame_pulse_counts_b", 7, 1, 2);

`ifdef VGA_SYNC_FRAME_CNT_EN
    hold_b(254 * 56);
    exp_st("frame_cnt_255_b", 1, 0, 0, 0, 1, 1, 1, 1, 1, 255);
    hold_b(2 * 56);
    exp_st("frame_cnt_wrap_b", 1, 0, 0, 0, 1, 1, 1, 1, 1, 1);
`endif

    // Mid-frame reset
    ticks_a(290);
    exp_st("x300_a", 0, 0, 300, 1, 1, 1, 1, 0, 0, 0);
    ticks_b(15);
    exp_st("x7_y1_b", 1, 0, 7, 1, 1, 1, 0, 0, 0, 1);
    @(posedge clk); #1 tick_b = 1'b1;  // B would wrap its line on the next edge
    #1 rst_n = 1'b0;
    exp_st("async_reset_a", 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    exp_st("async_reset_b", 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    exp_st("reset_no_pulse_b", 1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    @(posedge clk); #1 tick_b = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_st("post_release_b", 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    ticks_a(1); exp_st("tick_after_reset_a", 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    ticks_b(1); exp_st("tick_after_reset_b", 1, 0, 1, 0, 1, 1, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 CLK_NX  input  1  system clock (50 MHz); all state on its rising edge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 pixel_tick  input  1  one-cycle pixel enable from the clock divider (pixel_rate).
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 video_on  output  1  high while (pixel_x, pixel_y) is inside the visible area.
REQ-015 pixel_x  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-016 pixel_y  output  10  current vertical position, 0..V_TOTAL-1.
REQ-017 line_end  output  1  one-cycle pulse on the tick that wraps pixel_x.
REQ-018 frame_end  output  1  one-cycle pulse on the tick that wraps both pixel_x and pixel_y.

Function
REQ-019 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525) SHALL be derived constants.
REQ-020 Counters SHALL change only on cycles with pixel_tick=1; with pixel_tick=0, all outputs hold, except that the pulse outputs return to 0.
REQ-021 On each tick, pixel_x SHALL increment, and from H_TOTAL-1 it wraps to 0.
REQ-022 pixel_y SHALL increment only on a tick where pixel_x wraps, and from V_TOTAL-1 it wraps to 0.
REQ-023 Each axis SHALL run a phase FSM with states VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE.
REQ-024 Each phase transition SHALL occur on the tick that makes the axis count equal the phase start value: FRONT at 640/480, SYNC at 656/490, BACK at 752/492, VISIBLE at 0.
REQ-025 hsync SHALL be 0 exactly while the horizontal FSM is in SYNC, which is pixel_x in 656..751.
REQ-026 vsync SHALL be 0 exactly while the vertical FSM is in SYNC, which is pixel_y in 490..491.
REQ-027 video_on SHALL be 1 exactly when both FSMs are in VISIBLE.
REQ-028 All outputs SHALL be registered and mutually consistent in the same cycle; hsync, vsync and video_on have zero lag relative to pixel_x/pixel_y.
REQ-029 line_end and frame_end SHALL be asserted in the cycle after the wrapping tick, for exactly one CLK_NX cycle.
REQ-030 pixel_tick held high continuously SHALL advance the counters every cycle with no lost or extra steps.

Reset
REQ-031 While reset=0, the block SHALL force pixel_x=0, pixel_y=0, both FSMs to VISIBLE, hsync=1, vsync=1, video_on=1, line_end=0 and frame_end=0, asynchronously.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately; no pulse is emitted.
REQ-033 After reset is released, the first tick SHALL move pixel_x to 1.

Configuration
REQ-034 With macro VGA_SYNC_FRAME_CNT_EN defined, the block SHALL add output frame_cnt[7:0], reset to 0, which increments modulo 256 in the cycle frame_end asserts.
REQ-035 Without VGA_SYNC_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-036 Package vga_sync_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL, and the phase-state enumeration (VISIBLE, FRONT, SYNC, BACK).
REQ-037 Sub-module vga_axis_cnt SHALL implement one axis and be instantiated twice (horizontal, vertical).
REQ-038 vga_axis_cnt SHALL contain the counter and phase FSM, take an enable input, and provide wrap and sync_active outputs.

Verification
REQ-039 Reset low, then pixel_tick pulsing every 2nd cycle -> after 1 tick pixel_x=1, pixel_y=0, video_on=1, hsync=1.
REQ-040 Tick to pixel_x=656 -> hsync=0 and video_on=0 in the same cycle; hsync returns to 1 at pixel_x=752.
REQ-041 From pixel_x=799, pixel_y=524, one tick -> pixel_x=0, pixel_y=0, then line_end=1 and frame_end=1 for one cycle each.
REQ-042 Run a full frame at the divider rate (840000 CLK_NX cycles) -> exactly 525 line_end pulses, 1 frame_end pulse, and 2 lines with vsync=0.
REQ-043 Assert reset at pixel_x=300, pixel_y=200 -> all outputs take their reset values within the same cycle, and no pulse is emitted.
REQ-044 With VGA_SYNC_FRAME_CNT_EN defined, run 257 frames -> frame_cnt=1 after the wrap through 255.
